// File: rtl/rvfi_monitor_pkg.sv
// Shared types for the RVFI consistency monitor: violation codes, register-file
// geometry and the per-channel retirement control struct.
package rvfi_monitor_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        ERR_LIVENESS = 3'd0,
        ERR_ORDER    = 3'd1,
        ERR_PC       = 3'd2,
        ERR_RS1      = 3'd3,
        ERR_RS2      = 3'd4,
        ERR_GAP      = 3'd5,
        ERR_X0WR     = 3'd6,
        ERR_HALT     = 3'd7
    } err_code_e;

    typedef struct packed {
        logic                  valid;
        logic                  trap;
        logic                  halt;
        logic                  intr;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
    } rvfi_ctrl_t;

endpackage

// File: rtl/rvfi_shadow_regfile.sv
// Shadow copy of the architectural register file with NRET ordered write ports
// and two read ports per channel that see same-cycle writes of lower channels.
module rvfi_shadow_regfile
    import rvfi_monitor_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NRET = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NRET-1:0]                wr_en,
    input  logic [NRET*REG_ADDR_W-1:0]     wr_addr,
    input  logic [NRET*XLEN-1:0]           wr_data,
    input  logic [2*NRET*REG_ADDR_W-1:0]   rd_addr,
    output logic [2*NRET*XLEN-1:0]         rd_data,
    output logic [2*NRET-1:0]              rd_valid
);

    logic [XLEN-1:0]      regs_q [REG_COUNT];
    logic [XLEN-1:0]      regs_d [REG_COUNT];
    logic [REG_COUNT-1:0] valid_q, valid_d;

    // Writes applied in channel order so the highest channel wins on a shared rd.
    always_comb begin
        regs_d  = regs_q;
        valid_d = valid_q;
        for (int k = 0; k < NRET; k++) begin
            if (wr_en[k]) begin
                regs_d[wr_addr[k*REG_ADDR_W +: REG_ADDR_W]]  = wr_data[k*XLEN +: XLEN];
                valid_d[wr_addr[k*REG_ADDR_W +: REG_ADDR_W]] = 1'b1;
            end
        end
    end

    always_comb begin
        logic [REG_ADDR_W-1:0] addr;
        addr     = '0;
        rd_data  = '0;
        rd_valid = '0;
        for (int p = 0; p < 2*NRET; p++) begin
            addr                       = rd_addr[p*REG_ADDR_W +: REG_ADDR_W];
            rd_data[p*XLEN +: XLEN]    = regs_q[addr];
            rd_valid[p]                = valid_q[addr];
            for (int j = 0; j < NRET; j++) begin
                if ((j < p/2) && wr_en[j] && (wr_addr[j*REG_ADDR_W +: REG_ADDR_W] == addr)) begin
                    rd_data[p*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                    rd_valid[p]             = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    // Data is meaningless until its valid bit is set, so it carries no reset.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

endmodule

// File: rtl/rvfi_monitor.sv
// RVFI consistency monitor over NRET retirement channels with sticky first-error
// capture. Optional idle-liveness check enabled by RVFI_LIVENESS_CHECK_EN.
module rvfi_monitor
    import rvfi_monitor_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NRET    = 1,
    parameter int ORDER_W = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NRET-1:0]               rvfi_valid,
    input  logic [NRET*ORDER_W-1:0]       rvfi_order,
    input  logic [NRET-1:0]               rvfi_trap,
    input  logic [NRET-1:0]               rvfi_halt,
    input  logic [NRET-1:0]               rvfi_intr,
    input  logic [NRET*XLEN-1:0]          rvfi_pc_rdata,
    input  logic [NRET*XLEN-1:0]          rvfi_pc_wdata,
    input  logic [NRET*5-1:0]             rvfi_rs1_addr,
    input  logic [NRET*5-1:0]             rvfi_rs2_addr,
    input  logic [NRET*5-1:0]             rvfi_rd_addr,
    input  logic [NRET*XLEN-1:0]          rvfi_rs1_rdata,
    input  logic [NRET*XLEN-1:0]          rvfi_rs2_rdata,
    input  logic [NRET*XLEN-1:0]          rvfi_rd_wdata,
    output logic                          err,
    output logic [2:0]                    err_code,
    output logic [1:0]                    err_channel,
    output logic [ORDER_W-1:0]            err_order,
    output logic [ORDER_W-1:0]            retired
);

    rvfi_ctrl_t                     ctrl [NRET];
    logic [NRET-1:0]                wr_en;
    logic [2*NRET*REG_ADDR_W-1:0]   rs_addr;
    logic [2*NRET*XLEN-1:0]         sh_data;
    logic [2*NRET-1:0]              sh_valid;

    logic [ORDER_W-1:0] exp_order_q, exp_order_d;
    logic [XLEN-1:0]    exp_pc_q, exp_pc_d;
    logic               pc_known_q, pc_known_d;
    logic               halted_q, halted_d;
    logic [ORDER_W-1:0] retired_q, retired_d;
    logic               err_q, err_d;
    err_code_e          err_code_q, err_code_d;
    logic [1:0]         err_channel_q, err_channel_d;
    logic [ORDER_W-1:0] err_order_q, err_order_d;
    logic               idle_timeout;

    always_comb begin
        for (int k = 0; k < NRET; k++) begin
            ctrl[k].valid    = rvfi_valid[k];
            ctrl[k].trap     = rvfi_trap[k];
            ctrl[k].halt     = rvfi_halt[k];
            ctrl[k].intr     = rvfi_intr[k];
            ctrl[k].rs1_addr = rvfi_rs1_addr[k*REG_ADDR_W +: REG_ADDR_W];
            ctrl[k].rs2_addr = rvfi_rs2_addr[k*REG_ADDR_W +: REG_ADDR_W];
            ctrl[k].rd_addr  = rvfi_rd_addr[k*REG_ADDR_W +: REG_ADDR_W];
            wr_en[k]         = ctrl[k].valid && !ctrl[k].trap && (ctrl[k].rd_addr != '0);
            rs_addr[(2*k)*REG_ADDR_W +: REG_ADDR_W]   = ctrl[k].rs1_addr;
            rs_addr[(2*k+1)*REG_ADDR_W +: REG_ADDR_W] = ctrl[k].rs2_addr;
        end
    end

    rvfi_shadow_regfile #(.XLEN(XLEN), .NRET(NRET)) u_shadow (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (rvfi_rd_addr),
        .wr_data  (rvfi_rd_wdata),
        .rd_addr  (rs_addr),
        .rd_data  (sh_data),
        .rd_valid (sh_valid)
    );

`ifdef RVFI_LIVENESS_CHECK_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_q, idle_d;

    // Saturates at TIMEOUT so the timeout pulse fires only once per idle stretch.
    always_comb begin
        idle_d       = idle_q;
        idle_timeout = 1'b0;
        if (|rvfi_valid) begin
            idle_d = '0;
        end else if (!halted_q && (idle_q != IDLE_W'(TIMEOUT))) begin
            idle_d       = idle_q + IDLE_W'(1);
            idle_timeout = (idle_q == IDLE_W'(TIMEOUT - 1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`else
    assign idle_timeout = 1'b0;
`endif

    // Channels walk in index order; the running order/pc values forward lower
    // channels' effects to higher ones within the same cycle.
    always_comb begin
        logic               gap_seen, hit, bad_k;
        err_code_e          code_k;
        logic [1:0]         hit_ch;
        err_code_e          hit_code;
        logic [ORDER_W-1:0] hit_order, ord_k, ret_cnt;
        logic [XLEN-1:0]    rs1d, rs2d;

        exp_order_d = exp_order_q;
        exp_pc_d    = exp_pc_q;
        pc_known_d  = pc_known_q;
        halted_d    = halted_q;
        gap_seen    = 1'b0;
        hit         = 1'b0;
        bad_k       = 1'b0;
        code_k      = ERR_LIVENESS;
        hit_code    = ERR_LIVENESS;
        hit_ch      = '0;
        hit_order   = '0;
        ord_k       = '0;
        ret_cnt     = '0;
        rs1d        = '0;
        rs2d        = '0;

        for (int k = 0; k < NRET; k++) begin
            if (ctrl[k].valid) begin
                ord_k  = rvfi_order[k*ORDER_W +: ORDER_W];
                rs1d   = rvfi_rs1_rdata[k*XLEN +: XLEN];
                rs2d   = rvfi_rs2_rdata[k*XLEN +: XLEN];
                bad_k  = 1'b1;
                code_k = ERR_LIVENESS;
                if (ord_k != exp_order_d)
                    code_k = ERR_ORDER;
                else if (pc_known_d && !ctrl[k].intr && (rvfi_pc_rdata[k*XLEN +: XLEN] != exp_pc_d))
                    code_k = ERR_PC;
                else if (((ctrl[k].rs1_addr == '0) && (rs1d != '0)) ||
                         (sh_valid[2*k] && (rs1d != sh_data[(2*k)*XLEN +: XLEN])))
                    code_k = ERR_RS1;
                else if (((ctrl[k].rs2_addr == '0) && (rs2d != '0)) ||
                         (sh_valid[2*k+1] && (rs2d != sh_data[(2*k+1)*XLEN +: XLEN])))
                    code_k = ERR_RS2;
                else if (gap_seen)
                    code_k = ERR_GAP;
                else if ((ctrl[k].rd_addr == '0) && (rvfi_rd_wdata[k*XLEN +: XLEN] != '0))
                    code_k = ERR_X0WR;
                else if (halted_q)
                    code_k = ERR_HALT;
                else
                    bad_k = 1'b0;

                if (bad_k && !hit) begin
                    hit       = 1'b1;
                    hit_code  = code_k;
                    hit_ch    = 2'(k);
                    hit_order = ord_k;
                end

                exp_order_d = exp_order_d + ORDER_W'(1);
                exp_pc_d    = rvfi_pc_wdata[k*XLEN +: XLEN];
                pc_known_d  = 1'b1;
                if (ctrl[k].halt) halted_d = 1'b1;
                ret_cnt     = ret_cnt + ORDER_W'(1);
            end else begin
                gap_seen = 1'b1;
            end
        end

        retired_d = (retired_q > ~ret_cnt) ? '1 : retired_q + ret_cnt;

        err_d         = err_q;
        err_code_d    = err_code_q;
        err_channel_d = err_channel_q;
        err_order_d   = err_order_q;
        if (!err_q && hit) begin
            err_d         = 1'b1;
            err_code_d    = hit_code;
            err_channel_d = hit_ch;
            err_order_d   = hit_order;
        end else if (!err_q && idle_timeout) begin
            err_d         = 1'b1;
            err_code_d    = ERR_LIVENESS;
            err_channel_d = '0;
            err_order_d   = exp_order_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_order_q   <= '0;
            exp_pc_q      <= '0;
            pc_known_q    <= 1'b0;
            halted_q      <= 1'b0;
            retired_q     <= '0;
            err_q         <= 1'b0;
            err_code_q    <= ERR_LIVENESS;
            err_channel_q <= '0;
            err_order_q   <= '0;
        end else begin
            exp_order_q   <= exp_order_d;
            exp_pc_q      <= exp_pc_d;
            pc_known_q    <= pc_known_d;
            halted_q      <= halted_d;
            retired_q     <= retired_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            err_channel_q <= err_channel_d;
            err_order_q   <= err_order_d;
        end
    end

    assign err         = err_q;
    assign err_code    = err_code_q;
    assign err_channel = err_channel_q;
    assign err_order   = err_order_q;
    assign retired     = retired_q;

endmodule

// File: doc/rvfi_monitor.md
Name: rvfi_monitor

Overview:
- Parametrised, synthesizable RVFI consistency monitor; bound beside the `riscv` core in simulation and formal harnesses.
- Generalises the single-channel, combinational ISA-spec check to NRET retirement channels.
- Adds stateful cross-instruction checks: order sequencing, PC continuity, register read-after-write through a shadow register file, x0 integrity, halt finality.
- Reports the first violation as sticky registered outputs and counts retirements.

Parameters:
- XLEN, 32, datapath width of all rdata/wdata/pc fields.
- NRET, 1, retirement channels per cycle (1..4).
- ORDER_W, 64, width of rvfi_order per channel.
- TIMEOUT, 1024, liveness window in cycles (used only with RVFI_LIVENESS_CHECK_EN).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- rvfi_valid  input  NRET  channel retires this cycle
- rvfi_order  input  NRET*ORDER_W  retirement index
- rvfi_trap  input  NRET  instruction trapped
- rvfi_halt  input  NRET  last instruction before halt
- rvfi_intr  input  NRET  first instruction of a trap handler
- rvfi_pc_rdata  input  NRET*XLEN  PC of instruction
- rvfi_pc_wdata  input  NRET*XLEN  next PC
- rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  input  NRET*5 each  register indices
- rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata  input  NRET*XLEN each  register values
- err  output  1  sticky: a violation was seen
- err_code  output  3  code of first violation
- err_channel  output  2  channel of first violation
- err_order  output  ORDER_W  rvfi_order of offending retirement
- retired  output  ORDER_W  total retirements since reset

Behaviour:
- Reset: err=0, err_code=0, err_channel=0, err_order=0, retired=0, expected_order=0, pc_known=0, halted=0, all shadow valid bits=0.
- Channel validity: valid channels must form a prefix starting at channel 0.
  - rvfi_valid[k]=1 with rvfi_valid[j]=0 for some j<k -> code 5 (GAP), reported on channel k.
- Channels are evaluated in index order within a cycle. Channel k sees the order, PC and rd writes of valid channels j<k in the same cycle (combinational forwarding).
- Checks per valid channel, in priority (lowest code wins within a channel):
  - 1 ORDER: rvfi_order != expected_order.
  - 2 PC: pc_known && !rvfi_intr && pc_rdata != expected_pc.
  - 3 RS1: rs1_addr==0 && rs1_rdata!=0, or shadow valid && rs1_rdata != shadow.
  - 4 RS2: same as RS1 for rs2.
  - 6 X0WR: rd_addr==0 && rd_wdata!=0.
  - 7 HALT: any retirement while halted=1.
- State updates per valid channel:
  - expected_order += 1.
  - expected_pc = pc_wdata; pc_known=1.
  - If !rvfi_trap && rd_addr!=0: shadow[rd]=rd_wdata, valid bit set.
  - If rvfi_halt: halted=1.
  - retired increments by popcount(rvfi_valid), saturating at all-ones.
- Error capture:
  - The first violation registers err/err_code/err_channel/err_order on the next clock edge (1-cycle latency).
  - If several channels fail in one cycle, the lowest channel wins.
  - Later violations never overwrite the capture; only reset clears it.
  - Checking and state updates continue after err.
- Reset asserted mid-run clears all state asynchronously. Checking restarts with expected_order=0.

Optional Feature:
- Macro: RVFI_LIVENESS_CHECK_EN.
- Defined:
  - Idle counter counts cycles with no valid channel while halted=0; it clears on any retirement.
  - Reaching TIMEOUT raises code 0 with err=1 (err_channel=0, err_order=expected_order).
- Undefined: no counter is built; code 0 is never raised while err=1, so err=0 with err_code=0 means clean.

Decomposition:
- Package rvfi_monitor_pkg: err_code enum (LIVENESS=0, ORDER=1, PC=2, RS1=3, RS2=4, GAP=5, X0WR=6, HALT=7), REG_COUNT=32, and a per-channel retirement struct typedef parametrised via localparams.
- Sub-module rvfi_shadow_regfile:
  - 32 x XLEN entries plus valid bits.
  - NRET ordered write ports (higher channel wins on the same rd).
  - 2*NRET combinational read ports with same-cycle forwarding from lower channels.

Test Plan:
- NRET=1, orders 0,1,2 with pc 0x0->0x4->0x8 chained via pc_wdata -> err=0, retired=3.
- Retire order 0 then order 2 -> next cycle err=1, err_code=1, err_order=2.
- Retire addi x5 with rd_wdata=0x1234; next instr rs1_addr=5, rs1_rdata=0x1235 -> err_code=3, err_channel=0.
- NRET=2, same cycle: ch0 writes x7=0xAA, ch1 reads rs2=x7 as 0xAA -> no error. The same stimulus with ch1 reading 0xAB -> err_code=4, err_channel=1.
- rvfi_valid=2'b10 -> err_code=5, err_channel=1. Then a later PC error -> capture unchanged.
- Liveness: with RVFI_LIVENESS_CHECK_EN and TIMEOUT=16, 16 idle cycles -> err=1, err_code=0. Without the macro -> err stays 0. Async reset mid-run -> all outputs 0 immediately.
